// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
// Receives the raw PS/2 keyboard stream, deframes 11-bit frames (start, 8 data
// LSB first, odd parity, stop) and resolves E0/F0 prefixes into a held make code.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-high reset
//   ps2_clk    PS/2 clock line (asynchronous)
//   ps2_data   PS/2 data line (asynchronous)
//   key_code   currently held make code, 8'h00 when none is held
//   key_valid  one-cycle pulse per accepted make code (repeats included)
//   key_break  one-cycle pulse per accepted break code
//   key_ext    E0-prefix flag qualifying key_code and the pulses
//   frame_err  one-cycle pulse on parity, stop-bit or timeout error
module ps2_keyboard_rx #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_code,
   output logic       key_valid,
   output logic       key_break,
   output logic       key_ext,
   output logic       frame_err
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [7:0] BYTE_EXT = 8'hE0;
   localparam logic [7:0] BYTE_BRK = 8'hF0;
   localparam logic [7:0] BYTE_BAT = 8'hAA;
   localparam logic [7:0] BYTE_ACK = 8'hFA;
   localparam logic [7:0] BYTE_ECHO = 8'hEE;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [2:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          fall;
   logic          data_s;
   logic [7:0]    shift_reg;
   logic          par_bit;
   logic [2:0]    bit_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          brk_pend;
   logic          ext_pend;

   logic          timeout_c;
   logic          shift_c;
   logic          par_cap_c;
   logic          clr_cnt_c;
   logic          good_c;
   logic          bad_c;

   // Synchronizers; flops idle high like the bus
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync  <= 3'b111;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   assign fall   = clk_sync[2] & ~clk_sync[1];
   assign data_s = data_sync[1];

   // A fall in the same cycle restarts the count, so it wins over timeout
   assign timeout_c = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES));

   // Frame FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Frame FSM next-state and strobes
   always_comb begin
      state_nxt = state;
      shift_c   = 1'b0;
      par_cap_c = 1'b0;
      clr_cnt_c = 1'b0;
      good_c    = 1'b0;
      bad_c     = 1'b0;
      if (timeout_c) begin
         state_nxt = IDLE;
      end else if (fall) begin
         case (state)
            IDLE: begin
               // A high sample here is a glitch, not a start bit
               if (!data_s) begin
                  state_nxt = DATA;
                  clr_cnt_c = 1'b1;
               end
            end
            DATA: begin
               shift_c = 1'b1;
               if (bit_cnt == 3'd7) state_nxt = PARITY;
            end
            PARITY: begin
               par_cap_c = 1'b1;
               state_nxt = STOP;
            end
            STOP: begin
               state_nxt = IDLE;
               if (data_s && (^{shift_reg, par_bit})) good_c = 1'b1;
               else                                   bad_c  = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Deframing datapath: shift register, parity capture, bit counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg <= 8'h00;
         par_bit   <= 1'b0;
         bit_cnt   <= 3'd0;
      end else begin
         if (clr_cnt_c) bit_cnt <= 3'd0;
         if (shift_c) begin
            shift_reg <= {data_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
         end
         if (par_cap_c) par_bit <= data_s;
      end
   end

   // Inactivity counter, held at zero while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        tmo_cnt <= '0;
      else if (fall || state == IDLE) tmo_cnt <= '0;
      else                            tmo_cnt <= tmo_cnt + TW'(1);
   end

   // Byte decoder: prefix flags and registered key outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_code  <= 8'h00;
         key_valid <= 1'b0;
         key_break <= 1'b0;
         key_ext   <= 1'b0;
         frame_err <= 1'b0;
         brk_pend  <= 1'b0;
         ext_pend  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         key_break <= 1'b0;
         frame_err <= 1'b0;
         if (bad_c || timeout_c) begin
            frame_err <= 1'b1;
            brk_pend  <= 1'b0;
            ext_pend  <= 1'b0;
         end else if (good_c) begin
            if (shift_reg == BYTE_EXT) begin
               ext_pend <= 1'b1;
            end else if (shift_reg == BYTE_BRK) begin
               brk_pend <= 1'b1;
            end else if (shift_reg == BYTE_BAT || shift_reg == BYTE_ACK ||
                         shift_reg == BYTE_ECHO) begin
               brk_pend <= 1'b0;
               ext_pend <= 1'b0;
            end else begin
               if (!brk_pend) begin
                  key_code  <= shift_reg;
                  key_ext   <= ext_pend;
                  key_valid <= 1'b1;
               end else begin
                  key_break <= 1'b1;
                  key_ext   <= ext_pend;
                  // Release of a different key leaves the held code alone
                  if (shift_reg == key_code && ext_pend == key_ext) key_code <= 8'h00;
               end
               brk_pend <= 1'b0;
               ext_pend <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
module tb_ps2_keyboard_rx;

   logic       clk;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] key_code;
   logic       key_valid;
   logic       key_break;
   logic       key_ext;
   logic       frame_err;

   int vectors;
   int miscompares;
   int n_valid, n_break, n_err, n_excl;
   int s_valid, s_break, s_err;

   ps2_keyboard_rx #(.TIMEOUT_CYCLES(1000)) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_break (key_break),
      .key_ext   (key_ext),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled on the falling edge
   always @(negedge clk) begin
      if (!rst) begin
         if (key_valid) n_valid <= n_valid + 1;
         if (key_break) n_break <= n_break + 1;
         if (frame_err) n_err   <= n_err + 1;
         if ((int'(key_valid) + int'(key_break) + int'(frame_err)) > 1) n_excl <= n_excl + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive the first n bits of an 11-bit frame vector (bit 0 first)
   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         wait_clks(5);
         ps2_clk = 1'b0;
         wait_clks(10);
         ps2_clk = 1'b1;
         wait_clks(5);
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit);
      logic par;
      par = ~(^b) ^ bad_par;
      send_bits({stop_bit, par, b, 1'b0}, 11);
      wait_clks(10);
   endtask

   task automatic step_begin();
      s_valid = n_valid;
      s_break = n_break;
      s_err   = n_err;
   endtask

   task automatic step_end(input string tag, input int dv, input int db, input int de,
                           input logic [7:0] code, input logic ext);
      check({tag, "_valid"}, 32'(n_valid - s_valid), 32'(dv));
      check({tag, "_break"}, 32'(n_break - s_break), 32'(db));
      check({tag, "_err"},   32'(n_err - s_err),     32'(de));
      check({tag, "_code"},  32'(key_code),          32'(code));
      check({tag, "_ext"},   32'(key_ext),           32'(ext));
   endtask

   initial begin
      int lat;
      vectors = 0; miscompares = 0;
      n_valid = 0; n_break = 0; n_err = 0; n_excl = 0;
      ps2_clk = 1'b1; ps2_data = 1'b1;
      rst = 1'b1;
      wait_clks(4);
      check("rst_code",  32'(key_code),  32'h00);
      check("rst_valid", 32'(key_valid), 32'h0);
      check("rst_break", 32'(key_break), 32'h0);
      check("rst_ext",   32'(key_ext),   32'h0);
      check("rst_err",   32'(frame_err), 32'h0);
      rst = 1'b0;
      wait_clks(4);

      // Make
      step_begin(); send_frame(8'h1C, 1'b0, 1'b1);
      step_end("make", 1, 0, 0, 8'h1C, 1'b0);

      // Break prefix alone is silent, then release
      step_begin(); send_frame(8'hF0, 1'b0, 1'b1);
      step_end("f0", 0, 0, 0, 8'h1C, 1'b0);
      step_begin(); send_frame(8'h1C, 1'b0, 1'b1);
      step_end("brk", 0, 1, 0, 8'h00, 1'b0);

      // Extended make and break
      step_begin(); send_frame(8'hE0, 1'b0, 1'b1); send_frame(8'h75, 1'b0, 1'b1);
      step_end("extmk", 1, 0, 0, 8'h75, 1'b1);
      step_begin(); send_frame(8'hE0, 1'b0, 1'b1); send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h75, 1'b0, 1'b1);
      step_end("extbrk", 0, 1, 0, 8'h00, 1'b1);

      // Overlapping keys
      step_begin(); send_frame(8'h1C, 1'b0, 1'b1); send_frame(8'h32, 1'b0, 1'b1);
      step_end("ovl_mk", 2, 0, 0, 8'h32, 1'b0);
      step_begin(); send_frame(8'hF0, 1'b0, 1'b1); send_frame(8'h1C, 1'b0, 1'b1);
      step_end("ovl_brk", 0, 1, 0, 8'h32, 1'b0);

      // Ignored byte
      step_begin(); send_frame(8'hFA, 1'b0, 1'b1);
      step_end("ack", 0, 0, 0, 8'h32, 1'b0);

      // Parity and stop-bit errors
      step_begin(); send_frame(8'h1C, 1'b1, 1'b1);
      step_end("par", 0, 0, 1, 8'h32, 1'b0);
      step_begin(); send_frame(8'h1C, 1'b0, 1'b0);
      step_end("stop", 0, 0, 1, 8'h32, 1'b0);

      // Error clears pending break
      step_begin(); send_frame(8'hF0, 1'b0, 1'b1); send_frame(8'h44, 1'b1, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b1);
      step_end("errclr", 1, 0, 1, 8'h1C, 1'b0);

      // Timeout after a partial frame also clears the pending break
      step_begin(); send_frame(8'hF0, 1'b0, 1'b1);
      send_bits(11'b000_0110_1010, 5);
      // last pin fall was 15 clocks before send_bits returned
      lat = 15;
      while (!frame_err && lat < 1100) begin
         @(negedge clk);
         lat++;
      end
      check("tmo_lat", 32'((lat >= 1000 && lat <= 1010) ? 1 : 0), 32'h1);
      wait_clks(5);
      send_frame(8'h1C, 1'b0, 1'b1);
      step_end("tmo", 1, 0, 1, 8'h1C, 1'b0);

      // Reset mid-frame
      send_bits(11'b000_0110_1010, 5);
      rst = 1'b1;
      #1;
      check("mrst_code", 32'(key_code), 32'h00);
      check("mrst_ext",  32'(key_ext),  32'h0);
      wait_clks(3);
      rst = 1'b0;
      step_begin();
      wait_clks(50);
      step_end("mrst_idle", 0, 0, 0, 8'h00, 1'b0);
      step_begin(); send_frame(8'h32, 1'b0, 1'b1);
      step_end("mrst_mk", 1, 0, 0, 8'h32, 1'b0);

      check("exclusive", 32'(n_excl), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives the raw PS/2 keyboard serial stream (device-driven clock and data lines), deframes 11-bit frames, and resolves make/break/extended prefixes into a clean scan-code interface. Sits directly upstream of the scan-code-to-ASCII converter. It drives that converter's 8-bit `key_code` input with the currently held make code, or 8'h00 when no key is held. Runs entirely in the system clock domain; the PS/2 lines are treated as asynchronous inputs.

## Interface
- `TIMEOUT_CYCLES`, default 100000: system clocks without a PS/2 falling edge before a partial frame is aborted (2 ms at 50 MHz).
- `clk`  input  1  system clock; all state on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `ps2_clk`  input  1  PS/2 clock line, asynchronous.
- `ps2_data`  input  1  PS/2 data line, asynchronous.
- `key_code`  output  8  held make code of the last pressed key; 8'h00 when none is held.
- `key_valid`  output  1  one-cycle pulse on every accepted make code, typematic repeats included.
- `key_break`  output  1  one-cycle pulse on every accepted break code.
- `key_ext`  output  1  E0-prefix flag; qualifies `key_code` and the pulses.
- `frame_err`  output  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- **Synchronizer:** `ps2_clk` and `ps2_data` each pass through 2 flops. A third flop on the clock path feeds a falling-edge detector, `fall` = prev & ~cur. Data is sampled from its synchronized copy in the `fall` cycle.
- **Frame FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 (start bit), go to DATA and clear the bit counter. On `fall` with data=1, stay in IDLE with no error (glitch rejection).
  - DATA: shift data into an 8-bit register LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on `fall`, check the frame. It is good when the stop bit is 1 and ^{data, parity} == 1 (odd parity). A good frame goes to the decoder; a bad frame pulses `frame_err`. The FSM returns to IDLE either way.
- **Timeout:** a counter clears on every `fall` and runs while the FSM is outside IDLE. Reaching `TIMEOUT_CYCLES` forces IDLE, pulses `frame_err`, and clears the prefix flags.
- **Decoder:** two flags, `brk_pend` and `ext_pend`.
  - Byte 8'hE0 sets `ext_pend`. Byte 8'hF0 sets `brk_pend`. Neither produces an output pulse.
  - Any other byte with `brk_pend`=0 is a make: `key_code` ← byte, `key_ext` ← `ext_pend`, pulse `key_valid`.
  - Any other byte with `brk_pend`=1 is a break: pulse `key_break` and set `key_ext` ← `ext_pend`.
    - If the byte equals `key_code` and `ext_pend` equals `key_ext`, `key_code` ← 8'h00 in the same update.
    - Otherwise `key_code` is unchanged: a different key was released while another is still held.
  - After a make or break both flags clear. A frame error or timeout also clears both flags.
- **Ignored bytes:** 8'hAA (BAT OK), 8'hFA (ACK) and 8'hEE are dropped and clear the flags.

## Timing
- **Reset values:** `key_code`=8'h00, `key_valid`=0, `key_break`=0, `key_ext`=0, `frame_err`=0. FSM is in IDLE, counters and flags are 0, and the synchronizer flops are 1 (bus idle high).
- **Reset mid-frame:** the partial frame is discarded. There is no pulse after release, and the next start bit begins a fresh frame.
- **Input latency:** a pin falling edge is seen as `fall` 3 clocks later.
- **Output latency:**
  - `key_valid`, `key_break` and `frame_err` assert in the clock after the `fall` cycle of the stop bit, for exactly 1 cycle.
  - `key_code` and `key_ext` update in that same clock.
  - A timeout `frame_err` asserts in the clock after the counter reaches `TIMEOUT_CYCLES`.
- **Output exclusivity:** at most one of `key_valid`, `key_break` and `frame_err` is high in any cycle.
- **Minimum edge spacing:** `ps2_clk` edges must be at least 4 system clocks apart. The PS/2 bit period of 60–100 µs far exceeds this.
- **Hold behaviour:** `key_code` stays stable between updates. The downstream converter may sample it on any edge.

## Test plan
- **Make:** send frame 8'h1C with odd parity 0 → one `key_valid` pulse 1 clock after the stop edge; `key_code`=8'h1C, `key_ext`=0, no `frame_err`.
- **Break:** send 1C, then F0, then 1C → second `key_valid` absent; one `key_break` pulse after the final frame; `key_code`=8'h00. F0 alone produces no pulse.
- **Extended:** send E0 75, then E0 F0 75 → `key_valid` with `key_code`=8'h75 and `key_ext`=1; then `key_break` with `key_ext`=1 and `key_code`=8'h00.
- **Overlap:** send 1C, 32, then F0 1C → `key_code`=8'h32 after both makes; after the break of 1C it stays 8'h32 and `key_break` pulses.
- **Errors:**
  - Frame 8'h1C with parity flipped → `frame_err` pulse, no `key_valid`, `key_code` unchanged.
  - Stop bit 0 → same response.
  - F0 followed by a corrupt frame, then 1C → the 1C is treated as a make (flags cleared).
- **Timeout and reset:**
  - Drive 5 bits then stop toggling, with `TIMEOUT_CYCLES`=1000 → `frame_err` at cycle 1000 after the last `fall`; a following good frame decodes correctly.
  - Assert `rst` mid-frame → all outputs go to reset values immediately, and the next frame decodes correctly.
